// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Contents: FSM state enum, counter-width helper, two's-complement magnitude.
// Imported by mult_seq.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mult_state_t;

   // Bits needed to count 0..w iterations.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   // Magnitude of a two's-complement value. The caller sign-extends its
   // operand to 64 bits and size-casts the result back to its own width;
   // the most-negative value comes back as 2^(w-1), which is exact when
   // read as an unsigned w-bit number.
   function automatic logic [63:0] mag64(input logic [63:0] v);
      return v[63] ? (~v + 64'd1) : v;
   endfunction

endpackage

// File: rtl/mult_seq.sv
// Iterative radix-2 shift-add multiplier with a full 2*WIDTH-bit product,
// per-operation signed/unsigned mode, and valid/ready on both sides.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in1/in2/signed_mode
// (operand side); out_valid/out_ready/out (product side); busy (BUSY or DONE).
// Optional build macro MULT_SEQ_EARLY_EXIT_EN: leave BUSY as soon as the
// remaining multiplier is zero (at least one iteration). Results are the same.
module mult_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in1,
   input  logic [WIDTH-1:0]   in2,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out,
   output logic               busy
);

   localparam int CW = cnt_width(WIDTH);

   mult_state_t        state;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   logic               sign;

   logic [WIDTH-1:0]   in1_mag;
   logic [WIDTH-1:0]   in2_mag;
   logic [2*WIDTH-1:0] acc_sum;
   logic [WIDTH-1:0]   mplier_nxt;
   logic               last_iter;

   // The iteration runs on magnitudes; the sign is re-applied once at the end.
   always_comb begin
      in1_mag = in1;
      in2_mag = in2;
      if (signed_mode) begin
         in1_mag = WIDTH'(mag64(64'(signed'(in1))));
         in2_mag = WIDTH'(mag64(64'(signed'(in2))));
      end
   end

   always_comb begin
      acc_sum    = mplier[0] ? (acc + mcand) : acc;
      mplier_nxt = mplier >> 1;
      last_iter  = (cnt == CW'(WIDTH - 1));
`ifdef MULT_SEQ_EARLY_EXIT_EN
      // No set bits left means every later iteration would add nothing.
      if (mplier_nxt == '0)
         last_iter = 1'b1;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         cnt    <= '0;
         sign   <= 1'b0;
         out    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand  <= {WIDTH'(0), in1_mag};
                  mplier <= in2_mag;
                  acc    <= '0;
                  cnt    <= '0;
                  sign   <= signed_mode & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                  state  <= BUSY;
               end
            end
            BUSY: begin
               acc    <= acc_sum;
               mcand  <= mcand << 1;
               mplier <= mplier_nxt;
               cnt    <= cnt + 1'b1;
               if (last_iter) begin
                  // Uses this cycle's sum so the product lands on the same edge.
                  out   <= sign ? (~acc_sum + 1'b1) : acc_sum;
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   in1 = '0;
   logic [W-1:0]   in2 = '0;
   logic           signed_mode = 1'b0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [2*W-1:0] out;
   logic           busy;

   int n_cmp = 0;
   int n_err = 0;

   mult_seq #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in1        (in1),
      .in2        (in2),
      .signed_mode(signed_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out        (out),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_lat(input logic [W-1:0] b, input logic sm);
`ifdef MULT_SEQ_EARLY_EXIT_EN
      logic [W-1:0] m;
      int l;
      m = (sm && b[W-1]) ? (~b + 1'b1) : b;
      l = 1;
      for (int i = 0; i < W; i++)
         if (m[i]) l = i + 1;
      return l;
`else
      return W;
`endif
   endfunction

   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sm);
      logic [2*W-1:0] p;
      if (sm) p = $signed(a) * $signed(b);
      else    p = a * b;
      return p;
   endfunction

   // One full operation: accept, wait for the product, hold for 'hold' cycles
   // with out_ready low (pulsing in_valid, which must be ignored), then drain.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sm, input logic [2*W-1:0] expp, input int hold);
      int cyc;
      chk({tag, "/idle_ready"}, 64'(in_ready), 64'd1);
      in1         = a;
      in2         = b;
      signed_mode = sm;
      in_valid    = 1'b1;
      out_ready   = (hold == 0);
      step();
      in_valid = 1'b0;
      in1      = ~a;
      in2      = ~b;
      chk({tag, "/busy"}, 64'({in_ready, busy}), 64'b01);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         step();
         cyc++;
      end
      if (!out_valid) begin
         chk({tag, "/timeout"}, 64'(out_valid), 64'd1);
         return;
      end
      chk({tag, "/latency"}, 64'(cyc), 64'(exp_lat(b, sm)));
      chk({tag, "/out"}, 64'(out), 64'(expp));
      chk({tag, "/done_in_ready"}, 64'(in_ready), 64'd0);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         step();
         chk({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
         chk({tag, "/hold_out"}, 64'(out), 64'(expp));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk({tag, "/drained"}, 64'({out_valid, in_ready}), 64'b01);
      chk({tag, "/kept_out"}, 64'(out), 64'(expp));
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;

      #2;
      chk("reset_outs", 64'({in_ready, out_valid, busy}), 64'b100);
      chk("reset_out", 64'(out), 64'd0);
      step();
      rst = 1'b0;
      step();

      run_op("u13x11",    8'd13,  8'd11,  1'b0, 16'd143,  0);
      run_op("s-7x6",     8'hF9,  8'd6,   1'b1, 16'hFFD6, 0);
      run_op("s-128x-128",8'h80,  8'h80,  1'b1, 16'h4000, 0);
      run_op("u255x255",  8'hFF,  8'hFF,  1'b0, 16'hFE01, 0);
      run_op("s-128x1",   8'h80,  8'd1,   1'b1, 16'hFF80, 0);
      run_op("u0x77",     8'd0,   8'd77,  1'b0, 16'd0,    0);
      run_op("s-1x0",     8'hFF,  8'd0,   1'b1, 16'd0,    0);
      run_op("u9x5",      8'd9,   8'd5,   1'b0, 16'd45,   0);
      run_op("u3x128",    8'd3,   8'h80,  1'b0, 16'd384,  0);
      run_op("bp200x3",   8'd200, 8'd3,   1'b0, 16'd600,  5);

      // Reset in the middle of an operation.
      in1 = 8'd50; in2 = 8'd50; signed_mode = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      #1;
      chk("midrst_outs", 64'({in_ready, out_valid, busy}), 64'b100);
      chk("midrst_out", 64'(out), 64'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < W + 2; i++) begin
         step();
         chk("midrst_no_valid", 64'(out_valid), 64'd0);
      end
      run_op("post_rst2x3", 8'd2, 8'd3, 1'b0, 16'd6, 0);

      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rs = 1'($urandom_range(0, 1));
         run_op("rand", ra, rb, rs, ref_prod(ra, rb, rs), $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
